// File: rtl/button_pkg.sv
// Shared constants for the button game object stage: screen size, bar columns,
// serve position, frame tick row and object colours.
// Also holds a small inclusive-range helper used by every pixel/collision compare.
package button_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Bar columns (inclusive x range)
  localparam int BAR1_X_L = 32;
  localparam int BAR1_X_R = 35;
  localparam int BAR2_X_L = 604;
  localparam int BAR2_X_R = 607;

  // Serve / reset positions (top-left corners)
  localparam int BALL_X0 = 316;
  localparam int BALL_Y0 = 236;
  localparam int BAR_Y0  = 204;

  // Row on which the once-per-frame update tick fires (outside visible area)
  localparam int TICK_ROW = 481;

  localparam logic [2:0] RGB_NONE = 3'b000;
  localparam logic [2:0] RGB_BALL = 3'b100;
  localparam logic [2:0] RGB_BAR1 = 3'b001;
  localparam logic [2:0] RGB_BAR2 = 3'b110;

  // Inclusive range test on 12-bit screen coordinates
  function automatic logic in_span(input logic [11:0] p,
                                   input logic [11:0] lo,
                                   input logic [11:0] hi);
    return (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/button_bar.sv
// One player bar: vertical position register stepped on the frame tick and clamped
// to the screen, plus the combinational "pixel is on this bar" compare.
// Ports: clk/rst_n, tick, active-low key_up/key_dn, pixel_x/pixel_y in; bar_y, bar_on out.
module button_bar
  import button_pkg::*;
#(
  parameter int X_L   = BAR1_X_L,
  parameter int X_R   = BAR1_X_R,
  parameter int BAR_H = 72,
  parameter int BAR_V = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        key_up,
  input  logic        key_dn,
  input  logic [11:0] pixel_x,
  input  logic [11:0] pixel_y,
  output logic [9:0]  bar_y,
  output logic        bar_on
);

  // Lowest legal top coordinate: bar bottom sits on the last visible row
  localparam int Y_MAX = SCREEN_H - BAR_H;

  logic [9:0] y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (tick) begin
      // Exactly one key low moves the bar; both or neither hold it
      if (!key_up && key_dn) begin
        y_d = (y_q < 10'(BAR_V)) ? 10'd0 : y_q - 10'(BAR_V);
      end else if (key_up && !key_dn) begin
        y_d = (y_q > 10'(Y_MAX - BAR_V)) ? 10'(Y_MAX) : y_q + 10'(BAR_V);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= 10'(BAR_Y0);
    end else begin
      y_q <= y_d;
    end
  end

  assign bar_y  = y_q;
  assign bar_on = in_span(pixel_x, 12'(X_L), 12'(X_R)) &&
                  in_span(pixel_y, {2'b00, y_q}, {2'b00, y_q} + 12'(BAR_H - 1));

endmodule

// File: rtl/button_graph.sv
// Game objects: two bars and a ball advanced once per frame, miss pulses to the game
// FSM, and the zero-latency object/colour mux into the pixel stream.
// Ports: clk/rst_n, keys (active-low), stop, video_on, pixel_x/y in; graph_on, rgb_graph, miss1/2 out.
module button_graph
  import button_pkg::*;
#(
  parameter int BAR_H   = 72,
  parameter int BAR_V   = 4,
  parameter int BALL_SZ = 8,
  parameter int BALL_V  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key1,
  input  logic        key2,
  input  logic        key3,
  input  logic        key4,
  input  logic        stop,
  input  logic        video_on,
  input  logic [11:0] pixel_x,
  input  logic [11:0] pixel_y,
  output logic [2:0]  graph_on,
  output logic [2:0]  rgb_graph,
  output logic        miss1,
  output logic        miss2
);

  localparam logic [11:0] STEP    = 12'(BALL_V);
  localparam logic [11:0] SZ_M1   = 12'(BALL_SZ - 1);
  localparam logic [11:0] BAR_M1  = 12'(BAR_H - 1);
  localparam logic [11:0] BOT_LIM = 12'(SCREEN_H - 1 - BALL_V);
  localparam logic [11:0] RGT_LIM = 12'(SCREEN_W - 1 - BALL_V);

  logic tick;
  logic [9:0] bar1_y, bar2_y;
  logic bar1_on, bar2_on, ball_on;

  logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic vx_pos_q, vx_pos_d, vy_pos_q, vy_pos_d;
  logic miss1_q, miss1_d, miss2_q, miss2_d;

  assign tick = (pixel_x == 12'd0) && (pixel_y == 12'(TICK_ROW));

  button_bar #(
    .X_L(BAR1_X_L), .X_R(BAR1_X_R), .BAR_H(BAR_H), .BAR_V(BAR_V)
  ) u_bar1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .key_up(key1), .key_dn(key2),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .bar_y(bar1_y), .bar_on(bar1_on)
  );

  button_bar #(
    .X_L(BAR2_X_L), .X_R(BAR2_X_R), .BAR_H(BAR_H), .BAR_V(BAR_V)
  ) u_bar2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .key_up(key3), .key_dn(key4),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .bar_y(bar2_y), .bar_on(bar2_on)
  );

  // Ball edges and bar extents widened to screen-coordinate width
  logic [11:0] bx, by, bx_r, by_b, b1_t, b2_t;
  assign bx   = {2'b00, ball_x_q};
  assign by   = {2'b00, ball_y_q};
  assign bx_r = bx + SZ_M1;
  assign by_b = by + SZ_M1;
  assign b1_t = {2'b00, bar1_y};
  assign b2_t = {2'b00, bar2_y};

  logic wall_top, wall_bot, ov1, ov2, hit1, hit2, lost1, lost2, vx_new, vy_new;

  assign wall_top = (by <= STEP);
  assign wall_bot = (by_b >= BOT_LIM);
  assign ov1      = (by_b >= b1_t) && (by <= b1_t + BAR_M1);
  assign ov2      = (by_b >= b2_t) && (by <= b2_t + BAR_M1);
  // The catch window extends BALL_V past the bar face so a ball stepping
  // BALL_V per frame cannot skip over it
  assign hit1     = !vx_pos_q && in_span(bx, 12'(BAR1_X_L - BALL_V), 12'(BAR1_X_R)) && ov1;
  assign hit2     = vx_pos_q && in_span(bx_r, 12'(BAR2_X_L), 12'(BAR2_X_R + BALL_V)) && ov2;
  assign lost1    = !vx_pos_q && (bx <= STEP);
  assign lost2    = vx_pos_q && (bx_r >= RGT_LIM);
  // Wall and bar reflections are independent axes, so both can land on one tick
  assign vx_new   = hit1 ? 1'b1 : (hit2 ? 1'b0 : vx_pos_q);
  assign vy_new   = wall_top ? 1'b1 : (wall_bot ? 1'b0 : vy_pos_q);

  always_comb begin
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    vx_pos_d = vx_pos_q;
    vy_pos_d = vy_pos_q;
    miss1_d  = 1'b0;
    miss2_d  = 1'b0;
    if (tick) begin
      if (stop) begin
        ball_x_d = 10'(BALL_X0);
        ball_y_d = 10'(BALL_Y0);
      end else if (lost1) begin
        // Re-serve toward the player who just missed; vertical direction kept
        ball_x_d = 10'(BALL_X0);
        ball_y_d = 10'(BALL_Y0);
        vx_pos_d = 1'b0;
        miss1_d  = 1'b1;
      end else if (lost2) begin
        ball_x_d = 10'(BALL_X0);
        ball_y_d = 10'(BALL_Y0);
        vx_pos_d = 1'b1;
        miss2_d  = 1'b1;
      end else begin
        vx_pos_d = vx_new;
        vy_pos_d = vy_new;
        ball_x_d = vx_new ? ball_x_q + 10'(BALL_V) : ball_x_q - 10'(BALL_V);
        ball_y_d = vy_new ? ball_y_q + 10'(BALL_V) : ball_y_q - 10'(BALL_V);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ball_x_q <= 10'(BALL_X0);
      ball_y_q <= 10'(BALL_Y0);
      vx_pos_q <= 1'b1;
      vy_pos_q <= 1'b1;
      miss1_q  <= 1'b0;
      miss2_q  <= 1'b0;
    end else begin
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      vx_pos_q <= vx_pos_d;
      vy_pos_q <= vy_pos_d;
      miss1_q  <= miss1_d;
      miss2_q  <= miss2_d;
    end
  end

  assign miss1 = miss1_q;
  assign miss2 = miss2_q;

  assign ball_on = in_span(pixel_x, bx, bx_r) && in_span(pixel_y, by, by_b);

  always_comb begin
    graph_on  = 3'b000;
    rgb_graph = RGB_NONE;
    if (video_on) begin
      graph_on = {bar1_on, bar2_on, ball_on};
      if (ball_on) begin
        rgb_graph = RGB_BALL;
      end else if (bar1_on) begin
        rgb_graph = RGB_BAR1;
      end else if (bar2_on) begin
        rgb_graph = RGB_BAR2;
      end
    end
  end

endmodule

// File: tb/tb_button_graph.sv
module tb_button_graph;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key1, key2, key3, key4;
  logic        stop, video_on;
  logic [11:0] pixel_x, pixel_y;
  logic [2:0]  graph_on, rgb_graph;
  logic        miss1, miss2;

  int checks = 0;
  int errors = 0;
  int miss1_cnt = 0;
  int miss2_cnt = 0;

  // Reference model of the game state
  int mbx, mby, mvx, mvy, mb1, mb2;
  bit mm1, mm2;

  always #20 clk = ~clk;

  button_graph dut (
    .clk(clk), .rst_n(rst_n),
    .key1(key1), .key2(key2), .key3(key3), .key4(key4),
    .stop(stop), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .graph_on(graph_on), .rgb_graph(rgb_graph),
    .miss1(miss1), .miss2(miss2)
  );

  always @(posedge clk) begin
    if (miss1) miss1_cnt++;
    if (miss2) miss2_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bar_next(input int y, input logic up_n, input logic dn_n);
    if (!up_n && dn_n) return (y < 4) ? 0 : y - 4;
    if (up_n && !dn_n) return (y + 4 > 408) ? 408 : y + 4;
    return y;
  endfunction

  // One frame update, ball evaluated against the bar positions before they move
  task automatic model_step();
    int nvx, nvy;
    bit m1, m2, h1, h2;
    mm1 = 0;
    mm2 = 0;
    if (stop) begin
      mbx = 316;
      mby = 236;
    end else begin
      m1  = (mvx < 0) && (mbx <= 2);
      m2  = (mvx > 0) && (mbx + 7 >= 637);
      nvy = mvy;
      if (mby <= 2) nvy = 2;
      else if (mby + 7 >= 477) nvy = -2;
      h1  = (mvx < 0) && (mbx >= 30) && (mbx <= 35) && (mby + 7 >= mb1) && (mby <= mb1 + 71);
      h2  = (mvx > 0) && (mbx + 7 >= 604) && (mbx + 7 <= 609) && (mby + 7 >= mb2) && (mby <= mb2 + 71);
      nvx = h1 ? 2 : (h2 ? -2 : mvx);
      if (m1 || m2) begin
        mbx = 316;
        mby = 236;
        mvx = m1 ? -2 : 2;
        mm1 = m1;
        mm2 = m2;
      end else begin
        mvx = nvx;
        mvy = nvy;
        mbx = mbx + nvx;
        mby = mby + nvy;
      end
    end
    mb1 = bar_next(mb1, key1, key2);
    mb2 = bar_next(mb2, key3, key4);
  endtask

  // One ordinary cycle, then one tick cycle; returns at the negedge where a miss pulse is visible
  task automatic tick();
    pixel_x = 12'd100;
    pixel_y = 12'd490;
    @(posedge clk);
    @(negedge clk);
    pixel_x = 12'd0;
    pixel_y = 12'd481;
    @(posedge clk);
    @(negedge clk);
    model_step();
    check("state", 64'({dut.ball_x_q, dut.ball_y_q, dut.bar1_y, dut.bar2_y, dut.vx_pos_q, dut.vy_pos_q}),
          64'({10'(mbx), 10'(mby), 10'(mb1), 10'(mb2), (mvx > 0), (mvy > 0)}));
    check("miss", 64'({miss1, miss2}), 64'({mm1, mm2}));
    pixel_x = 12'd100;
    pixel_y = 12'd490;
  endtask

  task automatic steer(input int b, output logic up_n, output logic dn_n);
    int want;
    want = mby - 32;
    if (want < 0) want = 0;
    if (want > 408) want = 408;
    up_n = 1'b1;
    dn_n = 1'b1;
    if (b > want + 2) up_n = 1'b0;
    else if (b < want - 2) dn_n = 1'b0;
  endtask

  task automatic run_steered(input int n);
    repeat (n) begin
      steer(mb1, key1, key2);
      steer(mb2, key3, key4);
      tick();
    end
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic von, input logic [5:0] exp);
    @(negedge clk);
    pixel_x  = 12'(x);
    pixel_y  = 12'(y);
    video_on = von;
    #2;
    check(tag, 64'({graph_on, rgb_graph}), 64'(exp));
  endtask

  task automatic ball_chk(input string tag, input int x, input int y, input logic vxp, input logic vyp);
    check(tag, 64'({dut.ball_x_q, dut.ball_y_q, dut.vx_pos_q, dut.vy_pos_q}),
          64'({10'(x), 10'(y), vxp, vyp}));
  endtask

  initial begin
    rst_n = 1'b0; key1 = 1'b1; key2 = 1'b1; key3 = 1'b1; key4 = 1'b1;
    stop = 1'b1; video_on = 1'b0; pixel_x = 12'd100; pixel_y = 12'd100;
    repeat (3) @(negedge clk);
    check("rst_bars", 64'({dut.bar1_y, dut.bar2_y}), 64'({10'd204, 10'd204}));
    ball_chk("rst_ball", 316, 236, 1'b1, 1'b1);
    check("rst_miss", 64'({miss1, miss2}), 64'(0));
    check("rst_gfx", 64'({graph_on, rgb_graph}), 64'(0));
    rst_n = 1'b1;
    mbx = 316; mby = 236; mvx = 2; mvy = 2; mb1 = 204; mb2 = 204;

    // Frozen ball, idle keys
    repeat (3) tick();
    check("idle_bars", 64'({dut.bar1_y, dut.bar2_y}), 64'({10'd204, 10'd204}));
    ball_chk("idle_ball", 316, 236, 1'b1, 1'b1);

    // Both keys low: no move
    key1 = 1'b0; key2 = 1'b0;
    tick();
    check("both_keys", 64'(dut.bar1_y), 64'(204));
    // Key pressed only between ticks: ignored
    key1 = 1'b1; key2 = 1'b1;
    @(negedge clk); key1 = 1'b0;
    repeat (4) @(negedge clk);
    key1 = 1'b1;
    tick();
    check("key_between", 64'(dut.bar1_y), 64'(204));

    // Bar 1 up to the top and holding
    key1 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      check("bar1_up", 64'(dut.bar1_y), 64'((204 - 4 * i < 0) ? 0 : 204 - 4 * i));
    end
    key1 = 1'b1; key2 = 1'b0;
    tick();
    check("bar1_dn1", 64'(dut.bar1_y), 64'(4));
    repeat (109) tick();
    check("bar1_bot", 64'(dut.bar1_y), 64'(408));
    key2 = 1'b1; key3 = 1'b0;
    repeat (60) tick();
    check("bar2_top", 64'(dut.bar2_y), 64'(0));
    key3 = 1'b1;

    // Ball released right, bar 2 parked at top: passes bar 2 and is missed
    stop = 1'b0;
    repeat (157) tick();
    ball_chk("pre_miss2", 630, 390, 1'b1, 1'b0);
    check("no_miss_yet", 64'(miss1_cnt + miss2_cnt), 64'(0));
    tick();
    check("miss2_pulse", 64'({miss1, miss2}), 64'(2'b01));
    ball_chk("serve2", 316, 236, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    check("miss2_clr", 64'({miss1, miss2}), 64'(0));

    // Rally with bars tracking the ball
    run_steered(141);
    ball_chk("pre_bar2", 598, 50, 1'b1, 1'b1);
    run_steered(1);
    ball_chk("bar2_refl", 596, 52, 1'b0, 1'b1);
    run_steered(281);
    ball_chk("pre_bar1", 34, 326, 1'b0, 1'b0);
    // Ball overlapping bar 1: ball wins the colour
    probe("px_ball_bar1", 34, 328, 1'b1, {3'b101, 3'b100});
    probe("px_bar1_only", 33, 328, 1'b1, {3'b100, 3'b001});
    probe("px_ball_only", 40, 330, 1'b1, {3'b001, 3'b100});
    probe("px_ball_redge", 41, 333, 1'b1, {3'b001, 3'b100});
    probe("px_past_ball", 42, 330, 1'b1, 6'd0);
    probe("px_below_ball", 40, 334, 1'b1, 6'd0);
    probe("px_bar1_top", 33, mb1, 1'b1, {3'b100, 3'b001});
    probe("px_above_bar1", 33, mb1 - 1, 1'b1, 6'd0);
    probe("px_bar2", 605, mb2 + 10, 1'b1, {3'b010, 3'b110});
    probe("px_empty", 300, 300, 1'b1, 6'd0);
    probe("px_blank", 34, 328, 1'b0, 6'd0);
    @(negedge clk);
    video_on = 1'b0; pixel_x = 12'd100; pixel_y = 12'd490;
    run_steered(1);
    ball_chk("bar1_refl", 36, 324, 1'b1, 1'b0);
    check("no_miss1", 64'(miss1_cnt), 64'(0));
    run_steered(16073);
    ball_chk("pre_corner", 598, 2, 1'b1, 1'b0);
    run_steered(1);
    ball_chk("corner", 596, 4, 1'b0, 1'b1);

    // Stop re-centres with velocity kept, then bar 1 parked at top lets the ball through
    key1 = 1'b0; key2 = 1'b1; key3 = 1'b1; key4 = 1'b1;
    stop = 1'b1;
    tick();
    ball_chk("stop_hold", 316, 236, 1'b0, 1'b1);
    stop = 1'b0;
    repeat (157) tick();
    ball_chk("pre_miss1", 2, 390, 1'b0, 1'b0);
    check("bar1_parked", 64'(dut.bar1_y), 64'(0));
    tick();
    check("miss1_pulse", 64'({miss1, miss2}), 64'(2'b10));
    ball_chk("serve1", 316, 236, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    check("miss1_clr", 64'({miss1, miss2}), 64'(0));
    repeat (2) @(negedge clk);
    check("miss_counts", 64'({16'(miss1_cnt), 16'(miss2_cnt)}), 64'({16'd1, 16'd1}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
